// File: rtl/bm1387_result_collector_if.sv
// Result-collector bus: BM1387 result handshake on one side, FWFT readout and status on the other.
// The collector drives through the master modport; the ASIC/firmware environment uses slave.
interface bm1387_result_collector_if #(
  parameter int ADDR_W = 3
);
  logic              hash_valid;
  logic [31:0]       found_nonce;
  logic [255:0]      found_hash;
  logic [7:0]        job_id;
  logic              flush;
  logic              result_ack;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_job_id;
  logic [31:0]       res_nonce;
  logic [31:0]       res_hash_msw;
  logic [ADDR_W:0]   fifo_level;
  logic [15:0]       drop_count;
  logic              overflow;

  modport master (
    input  hash_valid, found_nonce, found_hash, job_id, flush, res_ready,
    output result_ack, res_valid, res_job_id, res_nonce, res_hash_msw,
           fifo_level, drop_count, overflow
  );

  modport slave (
    output hash_valid, found_nonce, found_hash, job_id, flush, res_ready,
    input  result_ack, res_valid, res_job_id, res_nonce, res_hash_msw,
           fifo_level, drop_count, overflow
  );
endinterface

// File: rtl/bm1387_result_collector.sv
// Captures BM1387 found-nonce results, acknowledges them to the ASIC and queues
// {job_id, nonce, hash MSW} in a first-word fall-through FIFO, counting overflow drops.
module bm1387_result_collector #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3,
  parameter int ACK_HOLD   = 2
) (
  input  logic                        clk_100m,
  input  logic                        reset_n,
  bm1387_result_collector_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam logic [3:0]        ACK_LAST   = 4'(ACK_HOLD - 1);
  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ZERO = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   LEVEL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W - 1){1'b0}}, 1'b1};

  state_t            state_r, state_next_s;
  logic [3:0]        ack_cnt_r, ack_cnt_next_s;
  logic              result_ack_r;
  logic              capture_s;

  logic [71:0]       mem_r [FIFO_DEPTH];
  logic [71:0]       head_s;
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic [15:0]       drop_r;
  logic              overflow_r;
  logic              not_empty_s, pop_s, push_s, drop_s;

  // FSM state, hold counter and registered ACK output
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      ack_cnt_r    <= 4'd0;
      result_ack_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      ack_cnt_r    <= ack_cnt_next_s;
      result_ack_r <= (state_next_s == ACK);
    end
  end

  // Next-state logic; a level still high after ACK parks in WAIT_LOW so it is captured once
  always_comb begin
    state_next_s   = state_r;
    ack_cnt_next_s = ack_cnt_r;
    capture_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.hash_valid) begin
          capture_s      = 1'b1;
          ack_cnt_next_s = 4'd0;
          state_next_s   = ACK;
        end else begin
          state_next_s   = IDLE;
        end
      end
      ACK: begin
        if (ack_cnt_r == ACK_LAST) begin
          state_next_s   = WAIT_LOW;
        end else begin
          ack_cnt_next_s = ack_cnt_r + 4'd1;
        end
      end
      WAIT_LOW: begin
        if (!bus.hash_valid) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_LOW;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FIFO push/pop/drop decisions; a pop frees the slot for a same-cycle push when full
  always_comb begin
    not_empty_s = (level_r != LEVEL_ZERO);
    pop_s       = not_empty_s && bus.res_ready;
    push_s      = capture_s && !bus.flush && ((level_r != DEPTH_L) || pop_s);
    drop_s      = capture_s && !bus.flush && (level_r == DEPTH_L) && !pop_s;
    head_s      = mem_r[rd_ptr_r];
  end

  // Entry storage; contents are only visible while counted by level_r, so no reset
  always_ff @(posedge clk_100m) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {bus.job_id, bus.found_nonce, bus.found_hash[255:224]};
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LEVEL_ZERO;
    end else if (bus.flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LEVEL_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Saturating drop counter and sticky overflow; unaffected by flush
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      drop_r     <= 16'd0;
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      drop_r     <= (drop_r == 16'hFFFF) ? drop_r : drop_r + 16'd1;
      overflow_r <= 1'b1;
    end
  end

  assign bus.result_ack   = result_ack_r;
  assign bus.res_valid    = not_empty_s;
  assign bus.res_job_id   = not_empty_s ? head_s[71:64] : 8'h00;
  assign bus.res_nonce    = not_empty_s ? head_s[63:32] : 32'h0000_0000;
  assign bus.res_hash_msw = not_empty_s ? head_s[31:0]  : 32'h0000_0000;
  assign bus.fifo_level   = level_r;
  assign bus.drop_count   = drop_r;
  assign bus.overflow     = overflow_r;

endmodule

// File: tb/tb_bm1387_result_collector.sv
// Randomized bench for bm1387_result_collector: an ASIC-like driver plus a queue-based
// reference model that is stepped and compared once per clock.
module tb_bm1387_result_collector;
  localparam int DEPTH    = 8;
  localparam int AW       = 3;
  localparam int ACK_HOLD = 2;

  typedef struct packed {
    logic [7:0]  job;
    logic [31:0] nonce;
    logic [31:0] msw;
  } entry_t;

  logic clk_100m = 1'b0;
  logic reset_n;
  always #5 clk_100m = ~clk_100m;

  bm1387_result_collector_if #(.ADDR_W(AW)) bus();

  bm1387_result_collector #(
    .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .ACK_HOLD(ACK_HOLD)
  ) dut (
    .clk_100m(clk_100m),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_checks;
  int          n_fail;
  entry_t      mq[$];
  int          m_drop;
  bit          m_ovf;
  int          ack_left;
  bit          hv_prev;
  int          rdy_mode;
  bit          flush_rand;
  bit          chk_en;
  logic [31:0] sent[10];
  logic [31:0] refill[8];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: update the model from the inputs present at the edge, compare, then drive.
  task automatic tick();
    entry_t e;
    bit     pop, cap;
    @(posedge clk_100m);
    if (!reset_n) begin
      mq.delete(); m_drop = 0; m_ovf = 1'b0; ack_left = 0; hv_prev = 1'b0;
    end else begin
      pop = (mq.size() != 0) && bus.res_ready;
      cap = bus.hash_valid && !hv_prev;
      hv_prev = bus.hash_valid;
      if (ack_left > 0) ack_left--;
      if (cap) ack_left = ACK_HOLD;
      e.job = bus.job_id; e.nonce = bus.found_nonce; e.msw = bus.found_hash[255:224];
      if (bus.flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (cap) begin
          if (mq.size() < DEPTH) mq.push_back(e);
          else begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1'b1;
          end
        end
      end
    end
    #2;
    if (reset_n && chk_en) begin
      e = (mq.size() != 0) ? mq[0] : '0;
      check_eq("result_ack",   64'(bus.result_ack),   64'(ack_left > 0));
      check_eq("res_valid",    64'(bus.res_valid),    64'(mq.size() != 0));
      check_eq("fifo_level",   64'(bus.fifo_level),   64'(mq.size()));
      check_eq("res_job_id",   64'(bus.res_job_id),   64'(e.job));
      check_eq("res_nonce",    64'(bus.res_nonce),    64'(e.nonce));
      check_eq("res_hash_msw", 64'(bus.res_hash_msw), 64'(e.msw));
      check_eq("drop_count",   64'(bus.drop_count),   64'(m_drop));
      check_eq("overflow",     64'(bus.overflow),     64'(m_ovf));
    end
    @(negedge clk_100m);
    case (rdy_mode)
      0:       bus.res_ready = 1'b0;
      1:       bus.res_ready = 1'($urandom_range(0, 1));
      default: bus.res_ready = 1'b1;
    endcase
    bus.flush = flush_rand && ($urandom_range(0, 15) == 0);
  endtask

  // ASIC behaviour: raise hash_valid, drop it one cycle after seeing ACK (plus extra hold).
  task automatic send(input logic [7:0] j, input logic [31:0] n, input int hold_extra,
                      input bit pop_cap, input bit flush_cap);
    int acks;
    bit fell;
    tick();
    bus.hash_valid  = 1'b1;
    bus.job_id      = j;
    bus.found_nonce = n;
    bus.found_hash  = rand256();
    if (pop_cap)   bus.res_ready = 1'b1;
    if (flush_cap) bus.flush     = 1'b1;
    tick();
    check_eq("ack_rise", 64'(bus.result_ack), 64'd1);
    acks = int'(bus.result_ack);
    bus.found_nonce = $urandom;
    bus.job_id      = 8'($urandom);
    bus.found_hash  = rand256();
    tick();
    acks += int'(bus.result_ack);
    repeat (hold_extra) begin
      tick();
      acks += int'(bus.result_ack);
      bus.found_nonce = $urandom;
    end
    bus.hash_valid = 1'b0;
    fell = 1'b0;
    for (int k = 0; k < 30 && !fell; k++) begin
      tick();
      if (bus.result_ack) acks++;
      else fell = 1'b1;
    end
    check_eq("ack_fell", 64'(fell), 64'd1);
    check_eq("ack_len", 64'(acks), 64'(ACK_HOLD));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_drop = 0; m_ovf = 1'b0; ack_left = 0; hv_prev = 1'b0;
    rdy_mode = 0; flush_rand = 1'b0; chk_en = 1'b0;
    reset_n = 1'b0;
    bus.hash_valid = 1'b0; bus.found_nonce = 32'h0; bus.found_hash = 256'h0;
    bus.job_id = 8'h00; bus.flush = 1'b0; bus.res_ready = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    check_eq("rst_ack",   64'(bus.result_ack), 64'd0);
    check_eq("rst_valid", 64'(bus.res_valid),  64'd0);
    check_eq("rst_level", 64'(bus.fifo_level), 64'd0);
    check_eq("rst_drop",  64'(bus.drop_count), 64'd0);
    check_eq("rst_ovf",   64'(bus.overflow),   64'd0);
    check_eq("rst_nonce", 64'(bus.res_nonce),  64'd0);
    chk_en = 1'b1;

    send(8'h05, 32'h1234_5678, 0, 1'b0, 1'b0);
    check_eq("single_nonce", 64'(bus.res_nonce),  64'h1234_5678);
    check_eq("single_job",   64'(bus.res_job_id), 64'h05);
    check_eq("single_level", 64'(bus.fifo_level), 64'd1);
    check_eq("single_valid", 64'(bus.res_valid),  64'd1);

    send(8'h06, 32'hCAFE_0001, 17, 1'b0, 1'b0);
    check_eq("hold_level", 64'(bus.fifo_level), 64'd2);

    tick(); bus.flush = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      sent[i] = $urandom;
      send(8'(i), sent[i], 0, 1'b0, 1'b0);
    end
    check_eq("ovf_level", 64'(bus.fifo_level), 64'd8);
    check_eq("ovf_drop",  64'(bus.drop_count), 64'd2);
    check_eq("ovf_flag",  64'(bus.overflow),   64'd1);
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("pop_order", 64'(bus.res_nonce), 64'(sent[i]));
    end
    rdy_mode = 0;
    tick();
    check_eq("drained", 64'(bus.fifo_level), 64'd0);

    for (int i = 0; i < 8; i++) begin
      refill[i] = $urandom;
      send(8'h40 + 8'(i), refill[i], 0, 1'b0, 1'b0);
    end
    send(8'h50, 32'hBEEF_0050, 0, 1'b1, 1'b0);
    check_eq("fullpop_level", 64'(bus.fifo_level), 64'd8);
    check_eq("fullpop_drop",  64'(bus.drop_count), 64'd2);
    check_eq("fullpop_head",  64'(bus.res_nonce),  64'(refill[1]));

    send(8'h60, 32'hF1F1_0060, 0, 1'b0, 1'b1);
    check_eq("flush_level", 64'(bus.fifo_level), 64'd0);
    check_eq("flush_valid", 64'(bus.res_valid),  64'd0);
    check_eq("flush_drop",  64'(bus.drop_count), 64'd2);

    rdy_mode = 1; flush_rand = 1'b1;
    for (int i = 0; i < 40; i++) send(8'($urandom), $urandom, $urandom_range(0, 3), 1'b0, 1'b0);
    rdy_mode = 0; flush_rand = 1'b0;

    tick(); bus.flush = 1'b1; tick();
    send(8'h71, 32'h0000_0071, 0, 1'b0, 1'b0);
    send(8'h72, 32'h0000_0072, 0, 1'b0, 1'b0);
    tick();
    bus.hash_valid = 1'b1; bus.job_id = 8'h73; bus.found_nonce = 32'h0000_0073;
    tick();
    check_eq("pre_rst_ack",   64'(bus.result_ack), 64'd1);
    check_eq("pre_rst_level", 64'(bus.fifo_level), 64'd3);
    reset_n = 1'b0;
    bus.hash_valid = 1'b0;
    #1;
    check_eq("midrst_ack",   64'(bus.result_ack), 64'd0);
    check_eq("midrst_level", 64'(bus.fifo_level), 64'd0);
    check_eq("midrst_drop",  64'(bus.drop_count), 64'd0);
    check_eq("midrst_ovf",   64'(bus.overflow),   64'd0);
    check_eq("midrst_valid", 64'(bus.res_valid),  64'd0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
